// File: rtl/agg_arb_pkg.sv
// Shared types, constants and helpers for the aggregate lane arbiter.
package agg_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int LW_DEF = 3;

  // grant index width; a single requester still needs a 1-bit index
  function automatic int grant_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/agg_lane_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr+1 modulo N.
module rr_pick
  import agg_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = grant_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic hit_v;
  int   cand_v;

  // priority scan starting just after the last winner
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    hit_v  = 1'b0;
    cand_v = 0;
    for (int k = 1; k <= N; k++) begin
      cand_v = (int'(ptr) + k) % N;
      hit_v  = req[cand_v] & ~any;
      idx    = hit_v ? W'(cand_v) : idx;
      any    = any | hit_v;
    end
  end

endmodule

// File: rtl/agg_lane_arbiter.sv
// Round-robin burst arbiter sharing one registered 3-lane aggregate output among NREQ sources.
// Optional idle-owner timeout enabled by defining AGG_ARB_TIMEOUT_EN.
module agg_lane_arbiter
  import agg_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LW      = LW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ*LW-1:0]         req_lane_0,
  input  logic [NREQ*LW-1:0]         req_lane_1,
  input  logic [NREQ*LW-1:0]         req_lane_2,
  output logic [NREQ-1:0]            req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LW-1:0]              out_lane_0,
  output logic [LW-1:0]              out_lane_1,
  output logic [LW-1:0]              out_lane_2,
  output logic                       out_last,
`ifdef AGG_ARB_TIMEOUT_EN
  output logic                       err_timeout,
`endif
  output logic [grant_w(NREQ)-1:0]   out_grant
);

  localparam int GW = grant_w(NREQ);

  arb_state_t    state_r, state_n_s;
  logic [GW-1:0] owner_r, owner_n_s;
  logic [GW-1:0] rr_ptr_r, rr_ptr_n_s;
  logic          pick_any_s;
  logic [GW-1:0] pick_idx_s;
  logic [GW-1:0] sel_s;
  logic          slot_free_s, accept_s, last_s, to_hit_s;
  logic          out_valid_r, out_last_r;
  logic [LW-1:0] lane_0_r, lane_1_r, lane_2_r;
  logic [GW-1:0] grant_r;

  rr_pick #(.N(NREQ), .W(GW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign slot_free_s = !out_valid_r || out_ready;
  assign sel_s       = (state_r == LOCKED) ? owner_r : pick_idx_s;
  assign last_s      = req_last[sel_s];
  assign accept_s    = slot_free_s &&
                       ((state_r == LOCKED) ? req_valid[owner_r] : pick_any_s);

  // one-hot ready toward the selected source; never depends on req_last
  always_comb begin
    req_ready = '0;
    if (state_r == LOCKED) begin
      req_ready[owner_r] = slot_free_s;
    end else if (pick_any_s) begin
      req_ready[pick_idx_s] = slot_free_s;
    end else begin
      req_ready = '0;
    end
  end

  // next-state: bursts lock the owner, last beats (or timeout) release it
  always_comb begin
    state_n_s  = state_r;
    owner_n_s  = owner_r;
    rr_ptr_n_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !last_s) begin
          state_n_s = LOCKED;
          owner_n_s = sel_s;
        end else if (accept_s) begin
          rr_ptr_n_s = sel_s;
        end else begin
          state_n_s = IDLE;
        end
      end
      LOCKED: begin
        if ((accept_s && last_s) || to_hit_s) begin
          state_n_s  = IDLE;
          rr_ptr_n_s = owner_r;
        end else begin
          state_n_s = LOCKED;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      owner_r  <= '0;
      rr_ptr_r <= GW'(NREQ - 1);
    end else begin
      state_r  <= state_n_s;
      owner_r  <= owner_n_s;
      rr_ptr_r <= rr_ptr_n_s;
    end
  end

  // output beat register: load on accept, drop when consumed, hold on stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      lane_0_r    <= '0;
      lane_1_r    <= '0;
      lane_2_r    <= '0;
      grant_r     <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= last_s;
      lane_0_r    <= req_lane_0[sel_s*LW +: LW];
      lane_1_r    <= req_lane_1[sel_s*LW +: LW];
      lane_2_r    <= req_lane_2[sel_s*LW +: LW];
      grant_r     <= sel_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_lane_0 = lane_0_r;
  assign out_lane_1 = lane_1_r;
  assign out_lane_2 = lane_2_r;
  assign out_grant  = grant_r;

`ifdef AGG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_r;
  logic          err_r;

  // only cycles where the owner has nothing to offer count toward release
  assign to_hit_s = (state_r == LOCKED) && !req_valid[owner_r] &&
                    (to_cnt_r == TW'(TIMEOUT - 1));

  // idle-owner counter and one-cycle error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= '0;
      err_r    <= 1'b0;
    end else begin
      err_r <= to_hit_s;
      if ((state_r != LOCKED) || accept_s || to_hit_s) begin
        to_cnt_r <= '0;
      end else if (!req_valid[owner_r]) begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  assign err_timeout = err_r;
`else
  assign to_hit_s = 1'b0;
`endif

endmodule

// File: doc/agg_lane_arbiter.md
Name: agg_lane_arbiter

Overview:
- Round-robin arbiter that shares one registered 3-lane aggregate output bus (out_lane_0..2) among NREQ requesters.
- Each requester offers a 3-lane aggregate beat with a valid/ready handshake.
- Multi-beat bursts, delimited by req_last, hold the grant until the last beat.
- Sits in front of the state-selected aggregate register muxes and sequences which source bank drives them.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LW, 3, width of each lane.
- TIMEOUT, 15, idle-owner cycles before forced release (used only with AGG_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  per-requester last beat of burst.
- req_lane_0  in  NREQ*LW  lane 0 data; requester i at bits [i*LW +: LW].
- req_lane_1  in  NREQ*LW  lane 1 data, same packing.
- req_lane_2  in  NREQ*LW  lane 2 data, same packing.
- req_ready  out  NREQ  per-requester accept.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_lane_0  out  LW  registered lane 0.
- out_lane_1  out  LW  registered lane 1.
- out_lane_2  out  LW  registered lane 2.
- out_last  out  1  registered last flag.
- out_grant  out  clog2(NREQ)  index of the source of the current output beat.
- err_timeout  out  1  timeout pulse (present only with AGG_ARB_TIMEOUT_EN).

Behaviour:
- Reset (rst=0, async) values:
  - out_valid=0, out_lane_0/1/2=0, out_last=0, out_grant=0.
  - state=IDLE, owner=0.
  - rr_ptr=NREQ-1, so requester 0 has first priority.
- slot_free = !out_valid || out_ready.
- Beat accepted from requester i when req_valid[i] && req_ready[i].
  - Lanes, last and grant are registered on that edge; out_valid=1 next cycle (latency 1).
- out_valid drops when out_ready=1 and no beat is accepted in the same cycle.
- Output registers hold while out_valid && !out_ready.
- Full throughput: back-to-back accepts when out_ready is held high.
- FSM IDLE:
  - winner g = first i with req_valid[i], scanning from rr_ptr+1 modulo NREQ.
  - req_ready[g] = slot_free; all other req_ready = 0.
  - Accept with req_last[g]=0: go to LOCKED, owner=g.
  - Accept with req_last[g]=1: stay in IDLE, rr_ptr=g.
  - No valid requester: all req_ready=0.
- FSM LOCKED:
  - Only owner is eligible: req_ready[owner] = slot_free; others 0, even if valid.
  - Accept with req_last=1: go to IDLE, rr_ptr=owner.
- rr_ptr updates only on an accepted last beat.
- req_ready is combinational from state, req_valid, out_valid and out_ready, with no dependency on req_last.
- req_ready is never asserted for more than one requester.
- Async reset mid-burst:
  - immediately clears out_valid and returns to IDLE;
  - the partial burst is dropped with no replay.

Optional Feature:
- Macro: AGG_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to LOCKED and on each owner accept.
  - It increments each LOCKED cycle with req_valid[owner]=0.
  - When it reaches TIMEOUT: FSM goes to IDLE, rr_ptr=owner, err_timeout=1 for one cycle, counter clears.
  - Stalls from out_ready=0 while the owner is valid do not count.
- Undefined: no counter and no err_timeout port; LOCKED persists until the owner's last beat.

Decomposition:
- Package agg_arb_pkg:
  - state enum {IDLE, LOCKED};
  - default lane width constant LW_DEF=3;
  - function grant_w(n) = clog2(n), minimum 1.
- Sub-module rr_pick:
  - combinational round-robin priority picker;
  - inputs req vector and ptr;
  - outputs any and idx.

Test Plan:
1. Reset with rst=0 while out_ready=1, then release -> out_valid=0, lanes 0, first grant goes to requester 0 when req_valid=2'b11.
2. NREQ=2, both valid with last=1 every beat, out_ready=1 -> grants alternate 0,1,0,1; out_lane_0 follows each source value (0->3'd1, 1->3'd6) one cycle after accept.
3. Requester 1 sends 3-beat burst (last on beat 3) while requester 0 is valid throughout -> req_ready[0]=0 for all 3 beats; out_grant=1 ×3, then 0.
4. out_ready=0 for 4 cycles with out_valid=1 -> output lanes hold their value; req_ready all 0; first accept occurs in the cycle out_ready returns to 1.
5. rst pulsed low mid-burst (after beat 1 of 3) -> out_valid=0 in the same cycle; FSM back in IDLE; the next accept arbitrates fresh starting at requester 0.
6. With AGG_ARB_TIMEOUT_EN and TIMEOUT=15: owner 0 goes idle mid-burst -> after 15 cycles err_timeout=1 for 1 cycle, then requester 1 is granted.
